// File: rtl/aqp_video_timing_if.sv
// rtl/aqp_video_timing_if.sv - video timing output bundle plus the mode request input.
interface aqp_video_timing_if;
  logic       mode_req;
  logic       video_mode;
  logic       video_hsync;
  logic       video_vsync;
  logic       video_de;
  logic       video_newframe;
  logic       video_oddline;
  logic [9:0] video_hpos;
  logic [8:0] video_vpos;
  logic [3:0] video_r;
  logic [3:0] video_g;
  logic [3:0] video_b;

  modport master (
    input  mode_req,
    output video_mode, video_hsync, video_vsync, video_de, video_newframe,
           video_oddline, video_hpos, video_vpos, video_r, video_g, video_b
  );

  modport slave (
    output mode_req,
    input  video_mode, video_hsync, video_vsync, video_de, video_newframe,
           video_oddline, video_hpos, video_vpos, video_r, video_g, video_b
  );
endinterface

// File: rtl/aqp_video_timing.sv
// rtl/aqp_video_timing.sv - raster timing generator, registered outputs, 480/240-line modes.
// Define AQP_VIDEO_TIMING_PATTERN_EN to drive an 8-bar colour test pattern on video_r/g/b.
module aqp_video_timing #(
  parameter int H_ACTIVE = 704,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 94,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                video_clk,
  input  logic                video_reset_n,
  aqp_video_timing_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          running;
  logic          frame_mode;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          line_end;
  logic          frame_end;
  logic          de_c;
  logic [3:0]    pat_r;
  logic [3:0]    pat_g;
  logic [3:0]    pat_b;

  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);
  assign de_c      = (hcnt < H_ACT) && (vcnt < V_ACT);

  // The first edge after reset release only arms the counters, so hcnt = vcnt = 0
  // is evaluated during the following clock and newframe lands on the second edge.
  always_ff @(posedge video_clk or negedge video_reset_n) begin
    if (!video_reset_n) begin
      running    <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      frame_mode <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
    end else begin
      hcnt <= line_end ? '0 : hcnt + 1'b1;
      if (line_end) begin
        vcnt <= frame_end ? '0 : vcnt + 1'b1;
      end
      if (frame_end) begin
        frame_mode <= vid.mode_req;
      end
    end
  end

`ifdef AQP_VIDEO_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_px;

  // Bar index tracks hcnt / BAR_W with a pixel counter instead of a divider.
  always_ff @(posedge video_clk or negedge video_reset_n) begin
    if (!video_reset_n) begin
      bar_idx <= '0;
      bar_px  <= '0;
    end else if (running) begin
      if (line_end) begin
        bar_idx <= '0;
        bar_px  <= '0;
      end else if (bar_px == BAR_LAST) begin
        bar_idx <= bar_idx + 1'b1;
        bar_px  <= '0;
      end else begin
        bar_px <= bar_px + 1'b1;
      end
    end
  end

  assign pat_r = {4{bar_idx[2]}};
  assign pat_g = {4{bar_idx[1]}};
  assign pat_b = {4{bar_idx[0]}};
`else
  assign pat_r = 4'h0;
  assign pat_g = 4'h0;
  assign pat_b = 4'h0;
`endif

  always_ff @(posedge video_clk or negedge video_reset_n) begin
    if (!video_reset_n) begin
      vid.video_mode     <= 1'b0;
      vid.video_hsync    <= 1'b1;
      vid.video_vsync    <= 1'b1;
      vid.video_de       <= 1'b0;
      vid.video_newframe <= 1'b0;
      vid.video_oddline  <= 1'b0;
      vid.video_hpos     <= '0;
      vid.video_vpos     <= '0;
      vid.video_r        <= '0;
      vid.video_g        <= '0;
      vid.video_b        <= '0;
    end else if (running) begin
      vid.video_mode     <= frame_mode;
      vid.video_hsync    <= !((hcnt >= HS_BEGIN) && (hcnt < HS_END));
      vid.video_vsync    <= !((vcnt >= VS_BEGIN) && (vcnt < VS_END));
      vid.video_de       <= de_c;
      vid.video_newframe <= (hcnt == '0) && (vcnt == '0);
      vid.video_oddline  <= vcnt[0];
      vid.video_hpos     <= (hcnt < H_ACT) ? 10'(hcnt) : 10'd0;
      vid.video_vpos     <= (vcnt < V_ACT) ? (frame_mode ? 9'(vcnt >> 1) : 9'(vcnt)) : 9'd0;
      vid.video_r        <= de_c ? pat_r : 4'h0;
      vid.video_g        <= de_c ? pat_g : 4'h0;
      vid.video_b        <= de_c ? pat_b : 4'h0;
    end
  end

endmodule

// File: tb/tb_aqp_video_timing.sv
// tb/tb_aqp_video_timing.sv - randomized bench for aqp_video_timing with a raster-arithmetic model.
module tb_aqp_video_timing;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int NF = 64;
  localparam logic [36:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 3'b000, 10'd0, 9'd0, 12'h000};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   k = 0;
  int   checks = 0;
  int   errors = 0;
  logic fm [NF];

  aqp_video_timing_if vif ();

  aqp_video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .video_clk     (clk),
    .video_reset_n (rst_n),
    .vid           (vif)
  );

  always #5 clk = ~clk;

  // k = rising edges since reset release; edge k shows raster position k-2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
      for (int i = 0; i < NF; i++) fm[i] = 1'b0;
    end else begin
      k = k + 1;
      if (k >= 2 && ((k - 2) % FT) == FT - 1 && (k - 1) / FT < NF)
        fm[(k - 1) / FT] = vif.mode_req;
    end
  end

  function automatic logic [36:0] model_vec(input int n);
    int h, v, f, bar;
    logic m, de;
    logic [3:0] r, g, b;
    h = n % HT;
    v = (n / HT) % VT;
    f = n / FT;
    m = (f < NF) ? fm[f] : 1'b0;
    de = (h < HA) && (v < VA);
    bar = h / (HA / 8);
    r = 4'h0; g = 4'h0; b = 4'h0;
`ifdef AQP_VIDEO_TIMING_PATTERN_EN
    if (de) begin
      r = bar[2] ? 4'hF : 4'h0;
      g = bar[1] ? 4'hF : 4'h0;
      b = bar[0] ? 4'hF : 4'h0;
    end
`endif
    return {m,
            !((h >= HA + HFP) && (h < HA + HFP + HS)),
            !((v >= VA + VFP) && (v < VA + VFP + VS)),
            de,
            (h == 0) && (v == 0),
            v[0],
            (h < HA) ? 10'(h) : 10'd0,
            (v < VA) ? 9'(m ? v / 2 : v) : 9'd0,
            r, g, b};
  endfunction

  function automatic logic [36:0] dut_vec();
    return {vif.video_mode, vif.video_hsync, vif.video_vsync, vif.video_de,
            vif.video_newframe, vif.video_oddline, vif.video_hpos, vif.video_vpos,
            vif.video_r, vif.video_g, vif.video_b};
  endfunction

  always @(negedge clk) begin
    logic [36:0] exp_v, act_v;
    exp_v = (!rst_n || k < 2) ? RESET_VEC : model_vec(k - 2);
    act_v = dut_vec();
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle k=%0d actual=%h expected=%h", k, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic wait_pos(input int target);
    int b;
    b = 0;
    while (!(rst_n && k >= 2 && (k - 2) == target)) begin
      @(negedge clk);
      b++;
      if (b > 8000) begin
        checks++;
        errors++;
        $display("FAIL wait_pos timeout actual_k=%0d expected_pos=%0d", k, target);
        return;
      end
    end
  endtask

  initial begin
    int nf, nf_k0, nf_k1, de_tot, vs_low, hs_low, de_rise, hs_fall, run, maxrun;
    logic prev_de, prev_hs;
    vif.mode_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_hsync", int'(vif.video_hsync), 1);
    chk("reset_vsync", int'(vif.video_vsync), 1);
    chk("reset_de", int'(vif.video_de), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    nf = 0; nf_k0 = -1; nf_k1 = -1; de_tot = 0; vs_low = 0; hs_low = 0;
    de_rise = -1; hs_fall = -1; run = 0; maxrun = 0; prev_de = 1'b0; prev_hs = 1'b1;
    for (int i = 1; i <= 2 * FT; i++) begin
      @(negedge clk);
      if (i == 1) chk("newframe_edge1", int'(vif.video_newframe), 0);
      if (i == 2) chk("newframe_edge2", int'(vif.video_newframe), 1);
      if (vif.video_newframe) begin
        if (nf == 0) nf_k0 = i;
        if (nf == 1) nf_k1 = i;
        nf++;
      end
      if (vif.video_de) begin de_tot++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      if (!vif.video_vsync) vs_low++;
      if (!vif.video_hsync) hs_low++;
      if (vif.video_de && !prev_de && de_rise < 0) de_rise = i;
      if (!vif.video_hsync && prev_hs && hs_fall < 0) hs_fall = i;
      prev_de = vif.video_de;
      prev_hs = vif.video_hsync;
    end
    chk("newframe_count", nf, 2);
    chk("newframe_spacing", nf_k1 - nf_k0, 336);
    chk("de_total", de_tot, 256);
    chk("de_run_len", maxrun, 16);
    chk("vsync_low_clocks", vs_low, 96);
    chk("hsync_low_clocks", hs_low, 84);
    chk("hsync_after_de", hs_fall - de_rise, 18);

    wait_pos(2 * FT + 3 * HT);
    vif.mode_req = 1'b1;
    wait_pos(2 * FT + 6 * HT);
    chk("mode_mid_frame", int'(vif.video_mode), 0);
    wait_pos(3 * FT);
    chk("mode_at_newframe", int'(vif.video_mode), 1);
    chk("newframe_with_mode", int'(vif.video_newframe), 1);
`ifdef AQP_VIDEO_TIMING_PATTERN_EN
    wait_pos(3 * FT + HT);
    chk("pat_px0_rgb", int'({vif.video_r, vif.video_g, vif.video_b}), 12'h000);
    wait_pos(3 * FT + HT + 2);
    chk("pat_px2_rgb", int'({vif.video_r, vif.video_g, vif.video_b}), 12'h00F);
    wait_pos(3 * FT + HT + 15);
    chk("pat_px15_rgb", int'({vif.video_r, vif.video_g, vif.video_b}), 12'hFFF);
    wait_pos(3 * FT + HT + 16);
    chk("pat_px16_rgb", int'({vif.video_r, vif.video_g, vif.video_b}), 12'h000);
`else
    wait_pos(3 * FT + HT + 2);
    chk("rgb_tied_zero", int'({vif.video_r, vif.video_g, vif.video_b}), 0);
`endif
    wait_pos(3 * FT + 5 * HT);
    chk("mode1_vpos", int'(vif.video_vpos), 2);
    chk("mode1_oddline", int'(vif.video_oddline), 1);
    vif.mode_req = 1'b0;

    for (int i = 0; i < 6 * FT; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2) vif.mode_req = 1'($urandom_range(0, 1));
    end

    wait_pos(((k - 2) / FT + 1) * FT + 3 * HT + 10);
    chk("pre_reset_hpos", int'(vif.video_hpos), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_hpos", int'(vif.video_hpos), 0);
    chk("async_reset_de", int'(vif.video_de), 0);
    chk("async_reset_hsync", int'(vif.video_hsync), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_edge1", int'(vif.video_newframe), 0);
    @(negedge clk);
    chk("rerelease_edge2", int'(vif.video_newframe), 1);
    chk("rerelease_mode", int'(vif.video_mode), 0);

    repeat (FT) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
